// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register in front of the ALU.
// Decodes RV32I opcode/funct3/funct7 into the ALU operation selector,
// forwards rs1/rs2 from EX/MEM and MEM/WB, selects ALU operands, and holds
// one entry behind a valid/ready handshake with flush.
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [31:0]      inInstr,
    input  logic [XLEN-1:0]  inPc,
    input  logic [XLEN-1:0]  inRs1Data,
    input  logic [XLEN-1:0]  inRs2Data,
    input  logic [XLEN-1:0]  inImm,
    input  logic             exmemRegWrite,
    input  logic [4:0]       exmemRd,
    input  logic [XLEN-1:0]  exmemResult,
    input  logic             memwbRegWrite,
    input  logic [4:0]       memwbRd,
    input  logic [XLEN-1:0]  memwbResult,
    input  logic             flush,
    input  logic             outReady,
    output logic             outValid,
    output logic [SEL_W-1:0] operationSelector,
    output logic [XLEN-1:0]  operandA,
    output logic [XLEN-1:0]  operandB,
    output logic [XLEN-1:0]  outStoreData,
    output logic [4:0]       outRd,
    output logic [XLEN-1:0]  outPc,
    output logic             outRegWrite,
    output logic             outMemRead,
    output logic             outMemWrite,
    output logic             outBranch,
    output logic             outJump,
    output logic             illegalInstr
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [SEL_W-1:0] SEL_BEQ  = 5'b00000;
    localparam logic [SEL_W-1:0] SEL_BNE  = 5'b00001;
    localparam logic [SEL_W-1:0] SEL_ADD  = 5'b00010;
    localparam logic [SEL_W-1:0] SEL_SUB  = 5'b00011;
    localparam logic [SEL_W-1:0] SEL_BGE  = 5'b00100;
    localparam logic [SEL_W-1:0] SEL_BLT  = 5'b00101;
    localparam logic [SEL_W-1:0] SEL_BGEU = 5'b00110;
    localparam logic [SEL_W-1:0] SEL_BLTU = 5'b00111;
    localparam logic [SEL_W-1:0] SEL_AND  = 5'b01000;
    localparam logic [SEL_W-1:0] SEL_OR   = 5'b01001;
    localparam logic [SEL_W-1:0] SEL_XOR  = 5'b01010;
    localparam logic [SEL_W-1:0] SEL_SLT  = 5'b01011;
    localparam logic [SEL_W-1:0] SEL_SLTU = 5'b01100;
    localparam logic [SEL_W-1:0] SEL_SLL  = 5'b01110;
    localparam logic [SEL_W-1:0] SEL_SRL  = 5'b01111;
    localparam logic [SEL_W-1:0] SEL_SRA  = 5'b10000;

    // Youngest producer wins; x0 is hard-wired to zero regardless of sources.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_we,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_val,
        input logic            wb_we,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_val
    );
        if (rs == 5'd0) begin
            return {XLEN{1'b0}};
        end else if (ex_we && (ex_rd == rs)) begin
            return ex_val;
        end else if (wb_we && (wb_rd == rs)) begin
            return wb_val;
        end else begin
            return rf_val;
        end
    endfunction

    // Arithmetic/logic selector shared by R-type and I-type ALU ops.
    // SUB exists only for R-type; the shift-right flavour follows instr[30].
    function automatic logic [SEL_W-1:0] alu_sel(
        input logic [2:0] funct3,
        input logic       alt,
        input logic       is_reg
    );
        case (funct3)
            3'b000:  return (is_reg && alt) ? SEL_SUB : SEL_ADD;
            3'b001:  return SEL_SLL;
            3'b010:  return SEL_SLT;
            3'b011:  return SEL_SLTU;
            3'b100:  return SEL_XOR;
            3'b101:  return alt ? SEL_SRA : SEL_SRL;
            3'b110:  return SEL_OR;
            3'b111:  return SEL_AND;
            default: return SEL_ADD;
        endcase
    endfunction

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [4:0]       w_rd;
    logic             w_rd_nz;
    logic [XLEN-1:0]  w_rs1_fwd;
    logic [XLEN-1:0]  w_rs2_fwd;
    logic [SEL_W-1:0] w_sel;
    logic [XLEN-1:0]  w_a;
    logic [XLEN-1:0]  w_b;
    logic             w_reg_write;
    logic             w_mem_read;
    logic             w_mem_write;
    logic             w_branch;
    logic             w_jump;
    logic             w_illegal;
    logic             w_capture;
    logic             w_unused_bits;

    logic             r_valid;
    logic [SEL_W-1:0] r_sel;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [XLEN-1:0]  r_store_data;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_pc;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_branch;
    logic             r_jump;
    logic             r_illegal;

    assign w_opcode      = inInstr[6:0];
    assign w_funct3      = inInstr[14:12];
    assign w_rd          = inInstr[11:7];
    assign w_rd_nz       = (w_rd != 5'd0);
    assign w_unused_bits = ^{inInstr[31], inInstr[29:25]};

    assign w_rs1_fwd = fwd_operand(inInstr[19:15], inRs1Data,
                                   exmemRegWrite, exmemRd, exmemResult,
                                   memwbRegWrite, memwbRd, memwbResult);
    assign w_rs2_fwd = fwd_operand(inInstr[24:20], inRs2Data,
                                   exmemRegWrite, exmemRd, exmemResult,
                                   memwbRegWrite, memwbRd, memwbResult);

    assign inReady   = !r_valid || outReady;
    assign w_capture = inValid && inReady && !flush;

    // Decode the incoming instruction into selector, operands and EX controls.
    always_comb begin
        w_sel       = SEL_ADD;
        w_a         = w_rs1_fwd;
        w_b         = inImm;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_illegal   = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_sel       = alu_sel(w_funct3, inInstr[30], 1'b1);
                w_b         = w_rs2_fwd;
                w_reg_write = w_rd_nz;
            end
            OP_I: begin
                w_sel       = alu_sel(w_funct3, inInstr[30], 1'b0);
                w_reg_write = w_rd_nz;
            end
            OP_LOAD: begin
                w_mem_read  = 1'b1;
                w_reg_write = w_rd_nz;
            end
            OP_STORE: begin
                w_mem_write = 1'b1;
            end
            OP_BRANCH: begin
                w_b      = w_rs2_fwd;
                w_branch = 1'b1;
                case (w_funct3)
                    3'b000:  w_sel = SEL_BEQ;
                    3'b001:  w_sel = SEL_BNE;
                    3'b100:  w_sel = SEL_BLT;
                    3'b101:  w_sel = SEL_BGE;
                    3'b110:  w_sel = SEL_BLTU;
                    3'b111:  w_sel = SEL_BGEU;
                    default: w_sel = SEL_BEQ;
                endcase
            end
            OP_JAL: begin
                w_a         = inPc;
                w_jump      = 1'b1;
                w_reg_write = w_rd_nz;
            end
            OP_JALR: begin
                w_jump      = 1'b1;
                w_reg_write = w_rd_nz;
            end
            OP_LUI: begin
                w_a         = {XLEN{1'b0}};
                w_reg_write = w_rd_nz;
            end
            OP_AUIPC: begin
                w_a         = inPc;
                w_reg_write = w_rd_nz;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Pipeline entry: flush beats capture, capture beats drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_sel        <= {SEL_W{1'b0}};
            r_a          <= {XLEN{1'b0}};
            r_b          <= {XLEN{1'b0}};
            r_store_data <= {XLEN{1'b0}};
            r_rd         <= 5'd0;
            r_pc         <= {XLEN{1'b0}};
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_branch     <= 1'b0;
            r_jump       <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid      <= 1'b1;
            r_sel        <= w_sel;
            r_a          <= w_a;
            r_b          <= w_b;
            r_store_data <= w_rs2_fwd;
            r_rd         <= w_rd;
            r_pc         <= inPc;
            r_reg_write  <= w_reg_write;
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_branch     <= w_branch;
            r_jump       <= w_jump;
            r_illegal    <= w_illegal;
        end else if (r_valid && outReady) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign outValid          = r_valid;
    assign operationSelector = r_sel;
    assign operandA          = r_a;
    assign operandB          = r_b;
    assign outStoreData      = r_store_data;
    assign outRd             = r_rd;
    assign outPc             = r_pc;
    assign outRegWrite       = r_reg_write;
    assign outMemRead        = r_mem_read;
    assign outMemWrite       = r_mem_write;
    assign outBranch         = r_branch;
    assign outJump           = r_jump;
    assign illegalInstr      = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios followed by randomized
// traffic, all compared against a mnemonic-table reference model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid, inReady;
    logic [31:0] inInstr, inPc, inRs1Data, inRs2Data, inImm;
    logic        exmemRegWrite, memwbRegWrite;
    logic [4:0]  exmemRd, memwbRd;
    logic [31:0] exmemResult, memwbResult;
    logic        flush, outReady, outValid;
    logic [4:0]  operationSelector, outRd;
    logic [31:0] operandA, operandB, outStoreData, outPc;
    logic        outRegWrite, outMemRead, outMemWrite, outBranch, outJump, illegalInstr;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
        .inInstr(inInstr), .inPc(inPc), .inRs1Data(inRs1Data), .inRs2Data(inRs2Data),
        .inImm(inImm), .exmemRegWrite(exmemRegWrite), .exmemRd(exmemRd),
        .exmemResult(exmemResult), .memwbRegWrite(memwbRegWrite), .memwbRd(memwbRd),
        .memwbResult(memwbResult), .flush(flush), .outReady(outReady),
        .outValid(outValid), .operationSelector(operationSelector),
        .operandA(operandA), .operandB(operandB), .outStoreData(outStoreData),
        .outRd(outRd), .outPc(outPc), .outRegWrite(outRegWrite),
        .outMemRead(outMemRead), .outMemWrite(outMemWrite), .outBranch(outBranch),
        .outJump(outJump), .illegalInstr(illegalInstr)
    );

    // Instruction classes of the reference table
    localparam int C_R = 0, C_I = 1, C_ISH = 2, C_LD = 3, C_ST = 4, C_BR = 5;
    localparam int C_JAL = 6, C_JALR = 7, C_LUI = 8, C_AUIPC = 9;
    localparam int N_OPS = 31;

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] sel;
        int         cls;
    } op_t;

    op_t ops [N_OPS];
    int  cur_op;
    int  n_cmp = 0;
    int  n_err = 0;

    // Reference-model view of the pipeline entry
    logic        m_valid, m_rw, m_mr, m_mw, m_br, m_j, m_ill;
    logic [4:0]  m_sel, m_rd;
    logic [31:0] m_a, m_b, m_sd, m_pc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        ops[0]  = '{7'h33, 3'd0, 7'h00, 5'b00010, C_R};   // ADD
        ops[1]  = '{7'h33, 3'd0, 7'h20, 5'b00011, C_R};   // SUB
        ops[2]  = '{7'h33, 3'd1, 7'h00, 5'b01110, C_R};   // SLL
        ops[3]  = '{7'h33, 3'd2, 7'h00, 5'b01011, C_R};   // SLT
        ops[4]  = '{7'h33, 3'd3, 7'h00, 5'b01100, C_R};   // SLTU
        ops[5]  = '{7'h33, 3'd4, 7'h00, 5'b01010, C_R};   // XOR
        ops[6]  = '{7'h33, 3'd5, 7'h00, 5'b01111, C_R};   // SRL
        ops[7]  = '{7'h33, 3'd5, 7'h20, 5'b10000, C_R};   // SRA
        ops[8]  = '{7'h33, 3'd6, 7'h00, 5'b01001, C_R};   // OR
        ops[9]  = '{7'h33, 3'd7, 7'h00, 5'b01000, C_R};   // AND
        ops[10] = '{7'h13, 3'd0, 7'h00, 5'b00010, C_I};   // ADDI
        ops[11] = '{7'h13, 3'd2, 7'h00, 5'b01011, C_I};   // SLTI
        ops[12] = '{7'h13, 3'd3, 7'h00, 5'b01100, C_I};   // SLTIU
        ops[13] = '{7'h13, 3'd4, 7'h00, 5'b01010, C_I};   // XORI
        ops[14] = '{7'h13, 3'd6, 7'h00, 5'b01001, C_I};   // ORI
        ops[15] = '{7'h13, 3'd7, 7'h00, 5'b01000, C_I};   // ANDI
        ops[16] = '{7'h13, 3'd1, 7'h00, 5'b01110, C_ISH}; // SLLI
        ops[17] = '{7'h13, 3'd5, 7'h00, 5'b01111, C_ISH}; // SRLI
        ops[18] = '{7'h13, 3'd5, 7'h20, 5'b10000, C_ISH}; // SRAI
        ops[19] = '{7'h03, 3'd2, 7'h00, 5'b00010, C_LD};  // LOAD
        ops[20] = '{7'h23, 3'd2, 7'h00, 5'b00010, C_ST};  // STORE
        ops[21] = '{7'h63, 3'd0, 7'h00, 5'b00000, C_BR};  // BEQ
        ops[22] = '{7'h63, 3'd1, 7'h00, 5'b00001, C_BR};  // BNE
        ops[23] = '{7'h63, 3'd4, 7'h00, 5'b00101, C_BR};  // BLT
        ops[24] = '{7'h63, 3'd5, 7'h00, 5'b00100, C_BR};  // BGE
        ops[25] = '{7'h63, 3'd6, 7'h00, 5'b00111, C_BR};  // BLTU
        ops[26] = '{7'h63, 3'd7, 7'h00, 5'b00110, C_BR};  // BGEU
        ops[27] = '{7'h6F, 3'd0, 7'h00, 5'b00010, C_JAL}; // JAL
        ops[28] = '{7'h67, 3'd0, 7'h00, 5'b00010, C_JALR};// JALR
        ops[29] = '{7'h37, 3'd0, 7'h00, 5'b00010, C_LUI}; // LUI
        ops[30] = '{7'h17, 3'd0, 7'h00, 5'b00010, C_AUIPC};// AUIPC
    end

    // Assemble an instruction; fields the class does not care about are randomized
    function automatic logic [31:0] build(input int idx, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = ops[idx].f7;
        f3 = ops[idx].f3;
        case (ops[idx].cls)
            C_I:                         f7 = 7'($urandom);
            C_LD, C_ST, C_JALR:          begin f3 = 3'($urandom); f7 = 7'($urandom); end
            C_JAL, C_LUI, C_AUIPC:       begin f3 = 3'($urandom); f7 = 7'($urandom); end
            default: ;
        endcase
        return {f7, rs2, rs1, f3, rd, ops[idx].opc};
    endfunction

    function automatic bit is_legal(input logic [6:0] opc);
        return opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    endfunction

    // Register value as seen after forwarding: newest writer wins, x0 reads 0
    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0)                          return 32'd0;
        if (exmemRegWrite && exmemRd == rs)      return exmemResult;
        if (memwbRegWrite && memwbRd == rs)      return memwbResult;
        return rf;
    endfunction

    task automatic model_capture();
        int cls;
        logic [31:0] r1, r2;
        r1      = fwd(inInstr[19:15], inRs1Data);
        r2      = fwd(inInstr[24:20], inRs2Data);
        m_valid = 1'b1;
        m_rd    = inInstr[11:7];
        m_pc    = inPc;
        m_sd    = r2;
        m_mr    = 1'b0; m_mw = 1'b0; m_br = 1'b0; m_j = 1'b0; m_rw = 1'b0;
        if (cur_op < 0) begin
            m_ill = 1'b1;
            m_sel = 5'b00010;
            m_a   = 32'd0;
            m_b   = 32'd0;
        end else begin
            cls   = ops[cur_op].cls;
            m_ill = 1'b0;
            m_sel = ops[cur_op].sel;
            m_a   = (cls == C_LUI) ? 32'd0 : ((cls == C_JAL || cls == C_AUIPC) ? inPc : r1);
            m_b   = (cls == C_R || cls == C_BR) ? r2 : inImm;
            m_rw  = (cls inside {C_R, C_I, C_ISH, C_LD, C_JAL, C_JALR, C_LUI, C_AUIPC})
                    && (m_rd != 5'd0);
            m_mr  = (cls == C_LD);
            m_mw  = (cls == C_ST);
            m_br  = (cls == C_BR);
            m_j   = (cls == C_JAL || cls == C_JALR);
        end
    endtask

    task automatic check_outputs();
        check_val("outValid", 32'(outValid), 32'(m_valid));
        if (m_valid) begin
            check_val("selector", 32'(operationSelector), 32'(m_sel));
            check_val("outRd", 32'(outRd), 32'(m_rd));
            check_val("outPc", outPc, m_pc);
            check_val("storeData", outStoreData, m_sd);
            check_val("regWrite", 32'(outRegWrite), 32'(m_rw));
            check_val("memRead", 32'(outMemRead), 32'(m_mr));
            check_val("memWrite", 32'(outMemWrite), 32'(m_mw));
            check_val("branch", 32'(outBranch), 32'(m_br));
            check_val("jump", 32'(outJump), 32'(m_j));
            check_val("illegal", 32'(illegalInstr), 32'(m_ill));
            if (!m_ill) begin
                check_val("operandA", operandA, m_a);
                check_val("operandB", operandB, m_b);
            end
        end
    endtask

    // Called just after a falling edge with inputs set; returns on the next falling edge
    task automatic step();
        logic cap, drain;
        #1;
        check_val("inReady", 32'(inReady), 32'(!m_valid || outReady));
        cap   = inValid && (!m_valid || outReady) && !flush;
        drain = m_valid && outReady;
        @(posedge clk);
        if (flush)      m_valid = 1'b0;
        else if (cap)   model_capture();
        else if (drain) m_valid = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_instr(input int idx, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2);
        cur_op  = idx;
        inInstr = build(idx, rd, rs1, rs2);
    endtask

    task automatic no_forward();
        exmemRegWrite = 1'b0; exmemRd = 5'd0; exmemResult = 32'd0;
        memwbRegWrite = 1'b0; memwbRd = 5'd0; memwbResult = 32'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        inValid = 1'b1; outReady = 1'b1; flush = 1'b0;
        inPc = 32'h100; inRs1Data = 32'h5; inRs2Data = 32'h6; inImm = 32'h7;
        no_forward();
        set_instr(16, 5'd5, 5'd1, 5'd15);
        m_valid = 1'b0;

        // Reset held with an instruction presented
        repeat (2) @(negedge clk);
        check_val("rst_outValid", 32'(outValid), 32'd0);
        check_val("rst_selector", 32'(operationSelector), 32'd0);
        check_val("rst_operandA", operandA, 32'd0);
        check_val("rst_operandB", operandB, 32'd0);
        check_val("rst_ctrl", 32'({outRegWrite, outMemRead, outMemWrite, outBranch, outJump, illegalInstr}), 32'd0);
        check_val("rst_inReady", 32'(inReady), 32'd1);
        rst_n = 1'b1;

        // SLLI x5,x1,15
        inRs1Data = 32'h0000000F; inImm = 32'h0000000F;
        step();
        check_val("slli_sel", 32'(operationSelector), 32'h0E);
        check_val("slli_A", operandA, 32'h0000000F);
        check_val("slli_B", operandB, 32'h0000000F);
        check_val("slli_rw", 32'(outRegWrite), 32'd1);
        check_val("slli_rd", 32'(outRd), 32'd5);

        // BLT then BLTU
        inRs1Data = 32'h0000000F; inRs2Data = 32'hF000000F;
        set_instr(23, 5'd9, 5'd1, 5'd2);
        step();
        check_val("blt_sel", 32'(operationSelector), 32'h05);
        check_val("blt_B", operandB, 32'hF000000F);
        check_val("blt_br", 32'(outBranch), 32'd1);
        check_val("blt_rw", 32'(outRegWrite), 32'd0);
        set_instr(25, 5'd9, 5'd1, 5'd2);
        step();
        check_val("bltu_sel", 32'(operationSelector), 32'h07);
        check_val("bltu_B", operandB, 32'hF000000F);

        // Forwarding priority with rs1=rs2=3
        set_instr(0, 5'd4, 5'd3, 5'd3);
        inRs1Data = 32'hAAAA0001; inRs2Data = 32'hAAAA0002;
        exmemRegWrite = 1'b1; exmemRd = 5'd3; exmemResult = 32'h11;
        memwbRegWrite = 1'b1; memwbRd = 5'd3; memwbResult = 32'h22;
        step();
        check_val("fwd_exmem_A", operandA, 32'h11);
        exmemRegWrite = 1'b0;
        step();
        check_val("fwd_memwb_A", operandA, 32'h22);
        set_instr(0, 5'd4, 5'd0, 5'd0);
        exmemRegWrite = 1'b1; exmemRd = 5'd0; memwbRd = 5'd0;
        step();
        check_val("fwd_x0_A", operandA, 32'd0);
        check_val("fwd_x0_B", operandB, 32'd0);
        no_forward();

        // Backpressure: three stalled cycles, then capture on release
        outReady = 1'b0;
        set_instr(10, 5'd6, 5'd2, 5'd3); inPc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("bp_inReady", 32'(inReady), 32'd0);
            check_val("bp_pc_held", outPc, 32'h100);
        end
        outReady = 1'b1;
        step();
        check_val("bp_release_valid", 32'(outValid), 32'd1);
        check_val("bp_release_pc", outPc, 32'h200);

        // Flush with a new instruction presented
        flush = 1'b1; inPc = 32'h300;
        step();
        check_val("flush_valid", 32'(outValid), 32'd0);
        flush = 1'b0;

        // Illegal opcode 0x7F
        cur_op = -1; inInstr = 32'h0000_02FF;
        step();
        check_val("ill_flag", 32'(illegalInstr), 32'd1);
        check_val("ill_sel", 32'(operationSelector), 32'h02);
        check_val("ill_ctrl", 32'({outRegWrite, outMemRead, outMemWrite, outBranch, outJump}), 32'd0);

        // Reset mid-operation with an entry stalled
        outReady = 1'b0;
        set_instr(0, 5'd7, 5'd1, 5'd2);
        step();
        rst_n = 1'b0;
        #1;
        check_val("midrst_valid", 32'(outValid), 32'd0);
        check_val("midrst_inReady", 32'(inReady), 32'd1);
        m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        outReady = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            inValid  = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 11) == 0) begin
                logic [6:0] opc;
                opc = 7'($urandom);
                while (is_legal(opc)) opc = 7'($urandom);
                cur_op  = -1;
                inInstr = {$urandom} & 32'hFFFF_FF80 | {25'd0, opc};
            end else begin
                set_instr($urandom_range(0, N_OPS - 1), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
            inPc          = $urandom;
            inRs1Data     = $urandom;
            inRs2Data     = $urandom;
            inImm         = $urandom;
            exmemRegWrite = 1'($urandom);
            exmemRd       = 5'($urandom_range(0, 7));
            exmemResult   = $urandom;
            memwbRegWrite = 1'($urandom);
            memwbRd       = 5'($urandom_range(0, 7));
            memwbResult   = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX pipeline register directly upstream of the ALU. It decodes RV32I opcode/funct3/funct7 into the 5-bit ALU operationSelector and muxes operandA/operandB from forwarded rs1/rs2, PC and the IMMGEN immediate. Its registered outputs drive the ALU inputs and the EX-stage control signals. It has a single-entry valid/ready handshake with flush and forwarding from EX/MEM and MEM/WB.

Parameters:
XLEN, 32, datapath width
SEL_W, 5, operationSelector width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
inValid  in  1  decode stage presents an instruction
inReady  out  1  stage can accept this cycle
inInstr  in  32  raw instruction
inPc  in  32  instruction PC
inRs1Data  in  32  register-file rs1 value
inRs2Data  in  32  register-file rs2 value
inImm  in  32  sign-extended immediate from IMMGEN
exmemRegWrite  in  1  EX/MEM writes rd
exmemRd  in  5  EX/MEM destination
exmemResult  in  32  EX/MEM value
memwbRegWrite  in  1  MEM/WB writes rd
memwbRd  in  5  MEM/WB destination
memwbResult  in  32  MEM/WB value
flush  in  1  kill held and incoming instruction
outReady  in  1  EX stage consumes entry
outValid  out  1  entry valid
operationSelector  out  5  to ALU
operandA  out  32  to ALU
operandB  out  32  to ALU
outStoreData  out  32  forwarded rs2, for stores
outRd  out  5  destination register
outPc  out  32  PC of entry
outRegWrite, outMemRead, outMemWrite, outBranch, outJump  out  1 each  EX/MEM control
illegalInstr  out  1  unsupported opcode in entry

Behaviour:
- Reset (async, rst_n=0): every output register cleared to 0, including outValid, operationSelector=00000 and all control bits. inReady is combinational and therefore 1 after reset.
- inReady = !outValid || outReady. Capture when inValid && inReady && !flush. Latency is 1 cycle: outputs are valid on the edge after capture.
- outValid: set on capture. Cleared on a consume-without-capture (outValid && outReady && no capture). Held with stable contents while outValid && !outReady.
- flush: outValid=0 next edge. The incoming instruction in the same cycle is dropped. Flush wins over capture and hold.
- Selector encoding: BEQ 00000, BNE 00001, ADD 00010, SUB 00011, BGE 00100, BLT 00101, BGEU 00110, BLTU 00111, AND 01000, OR 01001, XOR 01010, SLT 01011, SLTU 01100, SLL 01110, SRL 01111, SRA 10000.
- Decode:
  - R (0110011): funct3/funct7[5] select the op; B=rs2.
  - I-ALU (0010011): same ops, B=imm; SRAI when instr[30]=1; the ALU uses B[4:0] for shifts.
  - Loads (0000011), stores (0100011), JAL (1101111), JALR (1100111): ADD.
  - Branch (1100011): funct3 selects the branch code; A=rs1, B=rs2.
  - LUI: ADD with A=0, B=imm.
  - AUIPC and JAL: ADD with A=PC, B=imm.
  - JALR: A=rs1, B=imm.
- Control bits:
  - outRegWrite=1 for R, I-ALU, load, JAL, JALR, LUI and AUIPC, and only when rd!=0.
  - outMemRead=1 for loads; outMemWrite=1 for stores; outBranch=1 for branches; outJump=1 for JAL and JALR.
- Illegal opcode: captured with illegalInstr=1, selector ADD, all control bits 0.
- Forwarding is applied at capture only and independently for rs1 (instr[19:15]) and rs2 (instr[24:20]).
  - Priority: EX/MEM match (regWrite && rd==rs && rs!=0) > MEM/WB match > register file.
  - x0 always reads 0.
  - A held entry is not re-forwarded; the hazard unit guarantees this is safe.
- Reset mid-operation: the entry is discarded immediately and inReady=1 after release.

Test Plan:
- Reset: rst_n=0 while inValid=1 -> outValid=0, selector=00000, all outputs 0, inReady=1.
- SLLI x5,x1,15 (rs1=0x0000000F, imm=0x0000000F) -> next cycle selector=01110, A=0x0000000F, B=0x0000000F, outRegWrite=1, outRd=5.
- BLT and BLTU with rs1=0x0000000F, rs2=0xF000000F -> selector 00101, then 00111; operandB=0xF000000F; outBranch=1, outRegWrite=0.
- Forwarding with rs1=rs2=3:
  - exmemRd=3 (0x11), memwbRd=3 (0x22), both writing -> A=0x11.
  - EX/MEM write deasserted -> A=0x22.
  - rs=0 with both units targeting rd=0 -> A=0.
- Backpressure: outReady=0 for 3 cycles with inValid=1 -> inReady=0, outputs stable. Raise outReady -> next instruction captured on the same edge, no bubble.
- Flush while outValid=1 and a new inValid=1 -> outValid=0 next cycle. Opcode 0x7F -> illegalInstr=1, selector 00010, no writes.
